// File: rtl/wb_data_ram_slave.sv
`default_nettype none
// ============================================================================
// wb_data_ram_slave : Wishbone B3 classic data RAM slave, fixed wait states,
//                     big-endian byte lanes, err on out-of-range word index.
// Revision          : 1.0
// ============================================================================
module wb_data_ram_slave #(
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o
);

   localparam int          C_AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [29:0] C_MEM_WORDS = 30'(MEM_WORDS);
   localparam logic [3:0]  C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic        C_ZERO_WAIT = (WAIT_STATES == 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_latch;

   logic [29:0] r_adr;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_dat;

   logic [31:0] r_dat_o;
   logic        r_ack;
   logic        r_err;

   logic [31:0] r_mem [MEM_WORDS];

   logic        w_req;
   logic [29:0] w_idx;
   logic        w_we_eff;
   logic [3:0]  w_sel_eff;
   logic [31:0] w_dat_eff;
   logic        w_oor;
   logic        w_enter_resp;
   logic        w_wr_en;
   logic [31:0] w_rd_word;
   logic        w_unused;

   assign w_unused = ^wb_adr_i[1:0];
   assign w_req    = wb_cyc_i & wb_stb_i;

   // With zero wait states RESP is entered straight from IDLE, so the
   // live bus values stand in for the not-yet-latched request.
   assign w_idx     = (r_state == S_IDLE) ? wb_adr_i[31:2] : r_adr;
   assign w_we_eff  = (r_state == S_IDLE) ? wb_we_i        : r_we;
   assign w_sel_eff = (r_state == S_IDLE) ? wb_sel_i       : r_sel;
   assign w_dat_eff = (r_state == S_IDLE) ? wb_dat_i       : r_dat;

   assign w_oor        = (w_idx >= C_MEM_WORDS);
   assign w_enter_resp = (w_next == S_RESP);
   assign w_wr_en      = ~rst & w_enter_resp & w_we_eff & ~w_oor;
   assign w_rd_word    = r_mem[w_idx[C_AW-1:0]];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_latch    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_latch = 1'b1;
               if (C_ZERO_WAIT) begin
                  w_next = S_RESP;
               end else begin
                  w_next     = S_WAIT;
                  w_cnt_next = C_WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            // An abort wins even on the final wait cycle.
            if (!w_req) begin
               w_next     = S_IDLE;
               w_cnt_next = 4'd0;
            end else if (r_cnt == 4'd0) begin
               w_next = S_RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next     = S_IDLE;
            w_cnt_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_dat   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_latch) begin
            r_adr <= wb_adr_i[31:2];
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat_o <= '0;
      end else begin
         r_ack   <= w_enter_resp & ~w_oor;
         r_err   <= w_enter_resp & w_oor;
         r_dat_o <= (w_enter_resp & ~w_oor & ~w_we_eff) ? w_rd_word : 32'd0;
      end
   end

   // Memory is never reset; only selected byte lanes are updated.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (w_sel_eff[b]) begin
               r_mem[w_idx[C_AW-1:0]][8*b +: 8] <= w_dat_eff[8*b +: 8];
            end
         end
      end
   end

   assign wb_dat_o = r_dat_o;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_data_ram_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_data_ram_slave : checks two slave instances (1 and 3 wait states)
//                        against a word/byte-mask reference memory.
// Revision             : 1.0
// ============================================================================
module tb_wb_data_ram_slave;

   localparam int MEMW = 1024;
   localparam int WS0  = 1;
   localparam int WS1  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc  [2];
   logic        stb  [2];
   logic        we   [2];
   logic [31:0] adr  [2];
   logic [3:0]  sel  [2];
   logic [31:0] dat  [2];
   logic [31:0] dato [2];
   logic        ack  [2];
   logic        err  [2];

   int          total = 0;
   int          bad   = 0;
   int          ws [2];

   logic [31:0] mdl [2][MEMW];
   logic [3:0]  mv  [2][MEMW];

   always #5 clk = ~clk;

   wb_data_ram_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst(rst),
      .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
      .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dat[0]),
      .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
   );

   wb_data_ram_slave #(.MEM_WORDS(MEMW), .WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst(rst),
      .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
      .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dat[1]),
      .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_bus(input int d);
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
      we[d]  = 1'b0;
      adr[d] = '0;
      sel[d] = '0;
      dat[d] = '0;
   endtask

   // One bus transfer; returns response cycle index (-1 on timeout).
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input string tag, output int lat,
                       output bit ga, output bit ge, output logic [31:0] rd);
      @(posedge clk); #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat[d] = wd;
      lat = -1; ga = 1'b0; ge = 1'b0; rd = '0;
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         if (ack[d] === 1'b1 || err[d] === 1'b1) begin
            lat = n; ga = ack[d]; ge = err[d]; rd = dato[d];
            break;
         end
         if (n >= 1) begin
            // request already latched: later bus changes must be ignored
            adr[d] = $urandom; dat[d] = $urandom; sel[d] = 4'($urandom); we[d] = 1'($urandom);
         end
      end
      idle_bus(d);
      if (lat >= 0) begin
         @(negedge clk);
         chk({tag, "_pulse"}, {30'd0, ack[d], err[d]}, 32'd0);
         chk({tag, "_dat_clr"}, dato[d], 32'd0);
      end
   endtask

   task automatic op(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input string tag);
      int          lat;
      bit          ga, ge, oor;
      logic [31:0] rd, m;
      int          idx;
      xfer(d, w, a, s, wd, tag, lat, ga, ge, rd);
      idx = int'(a[31:2]);
      oor = (idx >= MEMW);
      chk({tag, "_lat"}, lat, ws[d] + 1);
      chk({tag, "_ack"}, {31'd0, ga}, {31'd0, !oor});
      chk({tag, "_err"}, {31'd0, ge}, {31'd0, oor});
      if (oor) begin
         chk({tag, "_errdat"}, rd, 32'd0);
      end else if (!w) begin
         m = {{8{mv[d][idx][3]}}, {8{mv[d][idx][2]}}, {8{mv[d][idx][1]}}, {8{mv[d][idx][0]}}};
         chk({tag, "_rdat"}, rd & m, mdl[d][idx] & m);
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
               mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
               mv[d][idx][b]         = 1'b1;
            end
         end
      end
   endtask

   task automatic abort_wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input bit use_rst, input string tag);
      bit seen = 1'b0;
      @(posedge clk); #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; sel[d] = 4'hF; dat[d] = wd;
      @(negedge clk);
      @(negedge clk);
      if (use_rst) begin
         rst = 1'b1;
         idle_bus(d);
         @(negedge clk);
         rst = 1'b0;
      end else begin
         idle_bus(d);
      end
      repeat (10) begin
         @(negedge clk);
         if (ack[d] === 1'b1 || err[d] === 1'b1) seen = 1'b1;
      end
      chk({tag, "_noresp"}, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      bit          seen;
      logic [29:0] ridx;
      logic [31:0] ra;
      ws[0] = WS0;
      ws[1] = WS1;
      for (int d = 0; d < 2; d++) begin
         idle_bus(d);
         for (int i = 0; i < MEMW; i++) begin
            mdl[d][i] = '0;
            mv[d][i]  = '0;
         end
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ack%0d", d), {31'd0, ack[d]}, 32'd0);
         chk($sformatf("rst_err%0d", d), {31'd0, err[d]}, 32'd0);
         chk($sformatf("rst_dat%0d", d), dato[d], 32'd0);
      end
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ack[0] === 1'b1 || ack[1] === 1'b1 || err[0] === 1'b1 || err[1] === 1'b1) seen = 1'b1;
      end
      chk("idle_noresp", {31'd0, seen}, 32'd0);

      op(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr_full");
      op(0, 1'b0, 32'h10, 4'hF, 32'h0,        "rd_full");
      op(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, "wr_byte");
      op(0, 1'b0, 32'h13, 4'b0000, 32'h0,     "rd_byte");
      op(0, 1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, "wr_nosel");
      op(0, 1'b0, 32'h14, 4'hF, 32'h0,        "rd_nosel");

      op(0, 1'b1, 32'h0,    4'hF, 32'h0BADF00D, "wr_w0");
      op(0, 1'b1, 32'h1000, 4'hF, 32'h55555555, "wr_oor");
      op(0, 1'b0, 32'h0,    4'hF, 32'h0,        "rd_w0");
      op(0, 1'b0, 32'h1000, 4'hF, 32'h0,        "rd_oor");
      op(0, 1'b1, 32'hFFC,  4'hF, 32'hA5A5C3C3, "wr_last");
      op(0, 1'b0, 32'hFFC,  4'hF, 32'h0,        "rd_last");

      op(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, "ws3_wr");
      abort_wr(1, 32'h20, 32'h12345678, 1'b0, "abort");
      op(1, 1'b0, 32'h20, 4'hF, 32'h0, "abort_rd");

      op(1, 1'b1, 32'h30, 4'hF, 32'h600DCAFE, "pre_rst_wr");
      abort_wr(1, 32'h30, 32'h87654321, 1'b1, "midrst");
      op(1, 1'b0, 32'h30, 4'hF, 32'h0, "post_rst_rd");
      op(0, 1'b0, 32'h10, 4'hF, 32'h0, "post_rst_rd0");

      for (int i = 0; i < 60; i++) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(0, 99) < 85) ridx = 30'($urandom_range(0, 15));
            else                            ridx = 30'($urandom_range(MEMW - 4, MEMW + 6));
            ra = {ridx, 2'($urandom)};
            op(d, 1'($urandom), ra, 4'($urandom), $urandom, $sformatf("rnd%0d_%0d", d, i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
